// File: rtl/phy_output_checker_pkg.sv
// Shared defaults and reset values for the phy output checker and its lane comparators.
package phy_output_checker_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic CHECK_RST  = 1'b1;
  localparam logic STICKY_RST = 1'b0;

endpackage

// File: rtl/phy_output_checker_lane.sv
// One lane of the phy output checker: registered match flag, sticky error flag and
// saturating mismatch counter, updated only while compare is enabled.
module phy_output_checker_lane
  import phy_output_checker_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_8f,
  input  logic              reset_L,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data_c,
  input  logic [DATA_W-1:0] i_data_e,
  output logic              o_check,
  output logic              o_err_sticky,
  output logic [CNT_W-1:0]  o_mismatch_cnt
);

  logic             w_match;
  logic             r_check;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  // An unknown equality result must fall into the else branch, so unknown bits count as mismatches.
  always_comb begin
    w_match = 1'b0;
    if (i_data_c == i_data_e) begin
      w_match = 1'b1;
    end else begin
      w_match = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_check  <= CHECK_RST;
      r_sticky <= STICKY_RST;
      r_cnt    <= '0;
    end else if (i_en) begin
      if (w_match) begin
        r_check <= 1'b1;
      end else begin
        r_check  <= 1'b0;
        r_sticky <= 1'b1;
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_check        = r_check;
  assign o_err_sticky   = r_sticky;
  assign o_mismatch_cnt = r_cnt;

endmodule

// File: rtl/phy_output_checker.sv
// Compares behavioural and structural phy lane outputs every clk_8f cycle, after an
// optional post-reset guard window, and keeps per-lane match/sticky/count results.
module phy_output_checker
  import phy_output_checker_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned GUARD_CYCLES = 0
) (
  input  logic              clk_8f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_out0_c,
  input  logic [DATA_W-1:0] data_out1_c,
  input  logic [DATA_W-1:0] data_out0_e,
  input  logic [DATA_W-1:0] data_out1_e,
  output logic              check_out0,
  output logic              check_out1,
  output logic              err_sticky0,
  output logic              err_sticky1,
  output logic [CNT_W-1:0]  mismatch_cnt0,
  output logic [CNT_W-1:0]  mismatch_cnt1
);

  // Keep at least one bit so GUARD_CYCLES=0 still yields a legal (always-zero) counter.
  localparam int unsigned GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  logic [GUARD_W-1:0] r_guard;
  logic               w_cmp_en;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_guard <= GUARD_W'(GUARD_CYCLES);
    end else if (r_guard != '0) begin
      r_guard <= r_guard - 1'b1;
    end
  end

  assign w_cmp_en = (r_guard == '0);

  phy_output_checker_lane #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lane0 (
    .clk_8f         (clk_8f),
    .reset_L        (reset_L),
    .i_en           (w_cmp_en),
    .i_data_c       (data_out0_c),
    .i_data_e       (data_out0_e),
    .o_check        (check_out0),
    .o_err_sticky   (err_sticky0),
    .o_mismatch_cnt (mismatch_cnt0)
  );

  phy_output_checker_lane #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lane1 (
    .clk_8f         (clk_8f),
    .reset_L        (reset_L),
    .i_en           (w_cmp_en),
    .i_data_c       (data_out1_c),
    .i_data_e       (data_out1_e),
    .o_check        (check_out1),
    .o_err_sticky   (err_sticky1),
    .o_mismatch_cnt (mismatch_cnt1)
  );

endmodule

// File: tb/tb_phy_output_checker.sv
// Bench for phy_output_checker: three instances (default, 2-bit counters, 4-cycle guard)
// fed from shared buses and checked against a behavioural model every cycle.
module tb_phy_output_checker;

  logic       clk_8f = 1'b0;
  logic       reset_L;
  logic [7:0] d_c [2];
  logic [7:0] d_e [2];

  logic        dm_chk0, dm_chk1, dm_st0, dm_st1;
  logic [15:0] dm_cnt0, dm_cnt1;
  logic        ds_chk0, ds_chk1, ds_st0, ds_st1;
  logic [1:0]  ds_cnt0, ds_cnt1;
  logic        dg_chk0, dg_chk1, dg_st0, dg_st1;
  logic [15:0] dg_cnt0, dg_cnt1;

  logic        chk_act [3][2];
  logic        st_act  [3][2];
  logic [15:0] cnt_act [3][2];

  always #5 clk_8f = ~clk_8f;

  phy_output_checker u_dut (
    .clk_8f(clk_8f), .reset_L(reset_L),
    .data_out0_c(d_c[0]), .data_out1_c(d_c[1]), .data_out0_e(d_e[0]), .data_out1_e(d_e[1]),
    .check_out0(dm_chk0), .check_out1(dm_chk1), .err_sticky0(dm_st0), .err_sticky1(dm_st1),
    .mismatch_cnt0(dm_cnt0), .mismatch_cnt1(dm_cnt1)
  );

  phy_output_checker #(.CNT_W(2)) u_dut_sat (
    .clk_8f(clk_8f), .reset_L(reset_L),
    .data_out0_c(d_c[0]), .data_out1_c(d_c[1]), .data_out0_e(d_e[0]), .data_out1_e(d_e[1]),
    .check_out0(ds_chk0), .check_out1(ds_chk1), .err_sticky0(ds_st0), .err_sticky1(ds_st1),
    .mismatch_cnt0(ds_cnt0), .mismatch_cnt1(ds_cnt1)
  );

  phy_output_checker #(.GUARD_CYCLES(4)) u_dut_guard (
    .clk_8f(clk_8f), .reset_L(reset_L),
    .data_out0_c(d_c[0]), .data_out1_c(d_c[1]), .data_out0_e(d_e[0]), .data_out1_e(d_e[1]),
    .check_out0(dg_chk0), .check_out1(dg_chk1), .err_sticky0(dg_st0), .err_sticky1(dg_st1),
    .mismatch_cnt0(dg_cnt0), .mismatch_cnt1(dg_cnt1)
  );

  assign chk_act[0][0] = dm_chk0;  assign chk_act[0][1] = dm_chk1;
  assign chk_act[1][0] = ds_chk0;  assign chk_act[1][1] = ds_chk1;
  assign chk_act[2][0] = dg_chk0;  assign chk_act[2][1] = dg_chk1;
  assign st_act[0][0]  = dm_st0;   assign st_act[0][1]  = dm_st1;
  assign st_act[1][0]  = ds_st0;   assign st_act[1][1]  = ds_st1;
  assign st_act[2][0]  = dg_st0;   assign st_act[2][1]  = dg_st1;
  assign cnt_act[0][0] = dm_cnt0;  assign cnt_act[0][1] = dm_cnt1;
  assign cnt_act[1][0] = {14'b0, ds_cnt0};
  assign cnt_act[1][1] = {14'b0, ds_cnt1};
  assign cnt_act[2][0] = dg_cnt0;  assign cnt_act[2][1] = dg_cnt1;

  // Behavioural model: one record per instance, counters kept as plain integers.
  typedef struct {
    int guard_load;
    int cnt_max;
    int guard;
    bit chk [2];
    bit st  [2];
    int cnt [2];
  } model_t;

  model_t mdl [3];

  typedef struct {
    logic [7:0] c0, e0, c1, e1;
    bit         x1;
    bit         exp_chk0, exp_chk1;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mdl[i].guard = mdl[i].guard_load;
      for (int l = 0; l < 2; l++) begin
        mdl[i].chk[l] = 1'b1;
        mdl[i].st[l]  = 1'b0;
        mdl[i].cnt[l] = 0;
      end
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 3; i++) begin
      if (mdl[i].guard > 0) begin
        mdl[i].guard--;
      end else begin
        for (int l = 0; l < 2; l++) begin
          if (d_c[l] !== d_e[l]) begin
            mdl[i].chk[l] = 1'b0;
            mdl[i].st[l]  = 1'b1;
            if (mdl[i].cnt[l] < mdl[i].cnt_max) mdl[i].cnt[l]++;
          end else begin
            mdl[i].chk[l] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 2; l++) begin
        check($sformatf("%s u%0d l%0d check", tag, i, l), 32'(chk_act[i][l]), 32'(mdl[i].chk[l]));
        check($sformatf("%s u%0d l%0d sticky", tag, i, l), 32'(st_act[i][l]), 32'(mdl[i].st[l]));
        check($sformatf("%s u%0d l%0d cnt", tag, i, l), 32'(cnt_act[i][l]), 32'(mdl[i].cnt[l]));
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk_8f);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive_random(input bit force_unequal);
    for (int l = 0; l < 2; l++) begin
      d_c[l] = 8'($urandom);
      if (force_unequal)                 d_e[l] = d_c[l] ^ 8'($urandom_range(1, 255));
      else if ($urandom_range(0, 1) == 1) d_e[l] = d_c[l];
      else                               d_e[l] = 8'($urandom);
    end
  endtask

  vec_t vecs [16];

  initial begin
    mdl[0].guard_load = 0; mdl[0].cnt_max = 65535;
    mdl[1].guard_load = 0; mdl[1].cnt_max = 3;
    mdl[2].guard_load = 4; mdl[2].cnt_max = 65535;

    for (int k = 0; k < 10; k++)
      vecs[k] = '{c0: 8'hBC, e0: 8'hBC, c1: 8'hDD, e1: 8'hDD, x1: 1'b0, exp_chk0: 1'b1, exp_chk1: 1'b1};
    for (int k = 10; k < 13; k++)
      vecs[k] = '{c0: 8'hEE, e0: 8'hEF, c1: 8'h55, e1: 8'h55, x1: 1'b0, exp_chk0: 1'b0, exp_chk1: 1'b1};
    vecs[13] = '{c0: 8'hEE, e0: 8'hEE, c1: 8'h55, e1: 8'h55, x1: 1'b0, exp_chk0: 1'b1, exp_chk1: 1'b1};
    vecs[14] = '{c0: 8'h3C, e0: 8'h3C, c1: 8'hA5, e1: 8'h00, x1: 1'b1, exp_chk0: 1'b1, exp_chk1: 1'b0};
    vecs[15] = '{c0: 8'h3C, e0: 8'h3C, c1: 8'hA5, e1: 8'hA5, x1: 1'b0, exp_chk0: 1'b1, exp_chk1: 1'b1};

    // Reset held across clock edges with unequal inputs.
    reset_L = 1'b0;
    drive_random(1'b1);
    model_reset();
    repeat (2) @(posedge clk_8f);
    #1;
    check_all("reset");
    check("reset main check0", 32'(dm_chk0), 32'd1);
    check("reset main cnt0", 32'(dm_cnt0), 32'd0);
    reset_L = 1'b1;

    // Table-driven directed vectors on the default instance.
    for (int k = 0; k < 16; k++) begin
      d_c[0] = vecs[k].c0;
      d_e[0] = vecs[k].e0;
      d_c[1] = vecs[k].c1;
      d_e[1] = vecs[k].x1 ? 8'hxx : vecs[k].e1;
      step($sformatf("vec%0d", k));
      check($sformatf("vec%0d check0", k), 32'(dm_chk0), 32'(vecs[k].exp_chk0));
      check($sformatf("vec%0d check1", k), 32'(dm_chk1), 32'(vecs[k].exp_chk1));
      if (k == 13) begin
        check("lane0 cnt after 3 bad", 32'(dm_cnt0), 32'd3);
        check("lane0 sticky", 32'(dm_st0), 32'd1);
        check("lane1 cnt untouched", 32'(dm_cnt1), 32'd0);
        check("lane1 sticky untouched", 32'(dm_st1), 32'd0);
      end
    end
    check("lane1 cnt after X", 32'(dm_cnt1), 32'd1);
    check("lane1 sticky after X", 32'(dm_st1), 32'd1);

    // Asynchronous reset mid-cycle, checked before any further clock edge.
    drive_random(1'b1);
    step("pre_async");
    #3 reset_L = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async main sticky0", 32'(dm_st0), 32'd0);
    check("async main cnt1", 32'(dm_cnt1), 32'd0);
    #1 reset_L = 1'b1;

    // Guard window and counter saturation with persistent mismatches.
    d_c[0] = 8'h12; d_e[0] = 8'h34;
    d_c[1] = 8'h56; d_e[1] = 8'h57;
    for (int k = 1; k <= 6; k++) begin
      step($sformatf("guard%0d", k));
      check($sformatf("guard edge%0d check0", k), 32'(dg_chk0), (k <= 4) ? 32'd1 : 32'd0);
      check($sformatf("guard edge%0d cnt0", k), 32'(dg_cnt0), (k <= 4) ? 32'd0 : 32'(k - 4));
      check($sformatf("sat edge%0d cnt0", k), 32'(ds_cnt0), (k < 3) ? 32'(k) : 32'd3);
      check($sformatf("main edge%0d cnt0", k), 32'(dm_cnt0), 32'(k));
    end

    // Randomised run with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      drive_random(1'b0);
      if ($urandom_range(0, 49) == 0) begin
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
        #1 reset_L = 1'b1;
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
